// File: rtl/add_issue_ctrl_if.sv
// add_issue_ctrl_if
//   Bundles the three handshakes around the issue/capture controller:
//   - operand intake:  in_valid / in_ready / in_a / in_b
//   - adder bus:       add_a / add_b / add_strobe / add_sum
//   - result delivery: out_valid / out_ready / out_sum / out_carry / out_mismatch
//   modport master : the controller's view (drives in_ready, adder operands,
//                    strobe and result signals)
//   modport slave  : the environment's view (producer, adder and consumer)
interface add_issue_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_strobe;
    logic [WIDTH-1:0] add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_mismatch;

    modport master (
        input  in_valid, in_a, in_b, add_sum, out_ready,
        output in_ready, add_a, add_b, add_strobe,
               out_valid, out_sum, out_carry, out_mismatch
    );

    modport slave (
        output in_valid, in_a, in_b, add_sum, out_ready,
        input  in_ready, add_a, add_b, add_strobe,
               out_valid, out_sum, out_carry, out_mismatch
    );
endinterface

// File: rtl/add_issue_ctrl.sv
// add_issue_ctrl
//   Issue/capture controller for a registered WIDTH-bit adder. Accepts one
//   operand pair, holds it on the adder bus for SETTLE cycles, pulses the
//   capture strobe for one cycle, waits LATENCY cycles, captures the adder
//   result and presents it with the reference carry and a mismatch flag.
//   One transaction is in flight at a time.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : add_issue_ctrl_if.master (intake, adder bus, result)
//     err_count : saturating count of captured mismatches
module add_issue_ctrl #(
    parameter int WIDTH   = 16,
    parameter int SETTLE  = 2,
    parameter int LATENCY = 1,
    parameter int ERRW    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    add_issue_ctrl_if.master      bus,
    output logic [ERRW-1:0]       err_count
);
    localparam int CNT_MAX = (SETTLE > LATENCY) ? SETTLE : LATENCY;
    localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLE - 1);
    localparam logic [CNTW-1:0] LAT_LD    = CNTW'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_STROBE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q;
    logic              accept;
    logic              capture;
    logic              mism;

    logic [WIDTH-1:0]  opa_p0, opb_p0;
    logic [WIDTH:0]    ref_p0;
    logic              strobe_p0;
    logic [WIDTH-1:0]  sum_p1;
    logic              carry_p1;
    logic              mism_p1;
    logic              vld_p1;
    logic [ERRW-1:0]   err_p1;

    // Counter saturates at all-ones instead of wrapping.
    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mism = (bus.add_sum != ref_p0[WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) state_d = S_STROBE;
            end
            S_STROBE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single down-counter times both the settle and the latency phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= SETTLE_LD;
        end else if (state_q == S_STROBE) begin
            cnt_q <= LAT_LD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Stage p0: operands and reference latched at acceptance. Strobe and
    // valid are registered from the next-state decode so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_p0    <= '0;
            opb_p0    <= '0;
            ref_p0    <= '0;
            strobe_p0 <= 1'b0;
        end else begin
            strobe_p0 <= (state_d == S_STROBE);
            if (accept) begin
                opa_p0 <= bus.in_a;
                opb_p0 <= bus.in_b;
                ref_p0 <= {1'b0, bus.in_a} + {1'b0, bus.in_b};
            end
        end
    end

    // Stage p1: result capture on the last WAIT edge; held until next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1   <= '0;
            carry_p1 <= 1'b0;
            mism_p1  <= 1'b0;
            vld_p1   <= 1'b0;
            err_p1   <= '0;
        end else begin
            vld_p1 <= (state_d == S_OUT);
            if (capture) begin
                sum_p1   <= bus.add_sum;
                carry_p1 <= ref_p0[WIDTH];
                mism_p1  <= mism;
                if (mism) err_p1 <= sat_inc(err_p1);
            end
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.add_a        = opa_p0;
    assign bus.add_b        = opb_p0;
    assign bus.add_strobe   = strobe_p0;
    assign bus.out_valid    = vld_p1;
    assign bus.out_sum      = sum_p1;
    assign bus.out_carry    = carry_p1;
    assign bus.out_mismatch = mism_p1;
    assign err_count        = err_p1;
endmodule

// File: tb/tb_add_issue_ctrl.sv
// tb_add_issue_ctrl
//   Directed bench for add_issue_ctrl with a behavioural registered adder
//   (captures add_a + add_b on a clock edge where add_strobe is high,
//   optionally adding 1 to model a faulty adder). Expected results are
//   pushed to a scoreboard queue at issue time and popped at delivery.
module tb_add_issue_ctrl;
    localparam int WIDTH   = 16;
    localparam int SETTLE  = 2;
    localparam int LATENCY = 1;
    localparam int ERRW    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ERRW-1:0] err_count;

    always #5 clk = ~clk;

    add_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    add_issue_ctrl #(
        .WIDTH(WIDTH), .SETTLE(SETTLE), .LATENCY(LATENCY), .ERRW(ERRW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .err_count (err_count)
    );

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             mm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   strobe_cnt = 0;
    int   fault_until = 0;
    bit   fault_all = 1'b0;
    int   exp_err = 0;
    logic [WIDTH-1:0] model_sum = '0;

    // Behavioural registered adder.
    always @(posedge clk) begin
        if (bus.add_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            if (fault_all || strobe_cnt < fault_until)
                model_sum <= bus.add_a + bus.add_b + 16'd1;
            else
                model_sum <= bus.add_a + bus.add_b;
        end
    end
    assign bus.add_sum = model_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        exp_t e;
        r = {1'b0, a} + {1'b0, b};
        e.mm    = fault_all || (strobe_cnt < fault_until);
        e.sum   = e.mm ? r[WIDTH-1:0] + 1'b1 : r[WIDTH-1:0];
        e.carry = r[WIDTH];
        if (e.mm && exp_err < 255) exp_err++;
        sb.push_back(e);
    endtask

    // Returns at the negedge following the acceptance edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("issue_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        push_exp(a, b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("add_a_latched", bus.add_a, a);
        check("add_b_latched", bus.add_b, b);
    endtask

    task automatic collect(input int gap);
        int t;
        exp_t e;
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        check("sb_nonempty", (sb.size() > 0), 1);
        if (!bus.out_valid || sb.size() == 0) return;
        e = sb.pop_front();
        bus.out_ready = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_sum", bus.out_sum, e.sum);
        end
        bus.out_ready = 1'b1;
        check("out_sum", bus.out_sum, e.sum);
        check("out_carry", bus.out_carry, e.carry);
        check("out_mismatch", bus.out_mismatch, e.mm);
        check("err_count", err_count, exp_err);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("valid_drop", bus.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        exp_t e;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_strobe", bus.add_strobe, 0);
        check("rst_add_a", bus.add_a, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_err", err_count, 0);
        rst_n = 1'b1;

        // Smoke: 2 + 4 with exact edge timing.
        issue(16'd2, 16'd4);
        @(negedge clk); check("smoke_strobe_e1", bus.add_strobe, 0);
        @(negedge clk); check("smoke_strobe_e2", bus.add_strobe, 1);
        @(negedge clk); check("smoke_strobe_e3", bus.add_strobe, 0);
        check("smoke_valid_e3", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        @(negedge clk); check("smoke_valid_e4", bus.out_valid, 1);
        collect(0);
        check("smoke_in_ready_e5", bus.in_ready, 1);

        // Carry.
        issue(16'd34952, 16'd34952);
        collect(0);

        // Backpressure with a competing in_valid.
        issue(16'd7, 16'd9);
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid", bus.out_valid, 1);
        e = sb.pop_front();
        bus.in_valid = 1'b1;
        bus.in_a     = 16'd100;
        bus.in_b     = 16'd200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_sum", bus.out_sum, e.sum);
            check("bp_add_a", bus.add_a, 16'd7);
        end
        check("bp_carry", bus.out_carry, e.carry);
        check("bp_mm", bus.out_mismatch, e.mm);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_valid_drop", bus.out_valid, 0);
        check("bp_idle", bus.in_ready, 1);
        check("bp_not_consumed", bus.add_a, 16'd7);
        push_exp(16'd100, 16'd200);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_consumed", bus.add_a, 16'd100);
        check("bp_busy", bus.in_ready, 0);
        collect(0);

        // Fault injection: next 3 adder results are off by one.
        fault_until = strobe_cnt + 3;
        for (int i = 0; i < 5; i++) begin
            issue(16'(i * 11 + 1), 16'(i * 7 + 3));
            collect(1);
        end
        check("fault_err3", err_count, 3);

        // Reset during STROBE.
        issue(16'd5, 16'd5);
        t = 0;
        while (!bus.add_strobe && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mid_strobe_seen", bus.add_strobe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_strobe_low", bus.add_strobe, 0);
        check("mid_valid_low", bus.out_valid, 0);
        check("mid_add_a", bus.add_a, 0);
        check("mid_add_b", bus.add_b, 0);
        check("mid_out_sum", bus.out_sum, 0);
        check("mid_carry", bus.out_carry, 0);
        check("mid_mm", bus.out_mismatch, 0);
        check("mid_err", err_count, 0);
        check("mid_in_ready", bus.in_ready, 1);
        sb.delete();
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", bus.out_valid, 0);
        end
        issue(16'd10, 16'd20);
        collect(0);
        check("post_rst_sum30", bus.out_sum, 30);

        // Random pairs with random consumer gaps.
        for (int i = 0; i < 10; i++) begin
            issue(16'($urandom_range(0, 9999)), 16'($urandom_range(0, 19999)));
            collect(int'($urandom_range(0, 3)));
        end

        // Saturation: 300 forced mismatches.
        fault_all = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(16'(i), 16'(i + 1));
            collect(0);
        end
        fault_all = 1'b0;
        check("sat_255", err_count, 255);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
